clock_time_ctrl: RTL and testbench

Time-keeping and time-setting controller for the digital clock. It samples the 1 Hz output of the 100 MHz divider as a synchronous tick in the CP_100MHz domain and maintains BCD hours/minutes/seconds. It runs a mode state machine driven by two debounced push-buttons, so the user can stop the clock and set hours and minutes. It sits between the divider and the display/scan logic.

---
 rtl/clock_time_ctrl.sv | 165 ++++++++++++++++
 tb/tb_clock_time_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/clock_time_ctrl.sv
// Digital clock time-keeping / time-setting controller: 1 Hz tick sampling,
// debounced MODE/INC keys, mode FSM and BCD hh:mm:ss. Optional: CLK_AUTOREPEAT_EN.
//
// state   | meaning
// RUN     | clock counts on every 1 Hz tick, INC ignored
// SET_HR  | clock stopped, INC steps hours 00-23
// SET_MIN | clock stopped, INC steps minutes 00-59
// ILLEGAL | unreachable code, returns to RUN
module clock_time_ctrl #(
  parameter int KEY_STABLE = 2000000
) (
  input  logic       CP_100MHz,
  input  logic       nCLR,
  input  logic       CP_1Hz,
  input  logic       KEY_MODE,
  input  logic       KEY_INC,
  output logic [7:0] Hour,
  output logic [7:0] Minute,
  output logic [7:0] Second,
  output logic [1:0] Mode
);

  localparam int CNT_W = (KEY_STABLE > 1) ? $clog2(KEY_STABLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_STABLE - 1);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  state_t state_q, state_d;

  logic             cp_r, cp_d, tick;
  logic [1:0]       key_s1, key_s2, key_db, key_db_d, press;
  logic [CNT_W-1:0] key_cnt [2];
  logic             mode_press, inc_press, inc_evt;
  logic [7:0]       hr_d, min_d, sec_d;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] maxv);
    logic [7:0] r;
    if (v == maxv)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Edge register resets high so a divider output already high at release does not tick.
  always_ff @(posedge CP_100MHz) begin
    if (!nCLR) begin
      cp_r <= 1'b1;
      cp_d <= 1'b1;
    end else begin
      cp_r <= CP_1Hz;
      cp_d <= cp_r;
    end
  end

  assign tick = cp_r & ~cp_d;

  // Bit 0 is MODE, bit 1 is INC.
  always_ff @(posedge CP_100MHz) begin
    if (!nCLR) begin
      key_s1   <= '0;
      key_s2   <= '0;
      key_db   <= '0;
      key_db_d <= '0;
      for (int i = 0; i < 2; i++) key_cnt[i] <= '0;
    end else begin
      key_s1   <= {KEY_INC, KEY_MODE};
      key_s2   <= key_s1;
      key_db_d <= key_db;
      for (int i = 0; i < 2; i++) begin
        if (key_s2[i] == key_db[i]) begin
          key_cnt[i] <= '0;
        end else if (key_cnt[i] == CNT_LAST) begin
          key_db[i]  <= key_s2[i];
          key_cnt[i] <= '0;
        end else begin
          key_cnt[i] <= key_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press      = key_db & ~key_db_d;
  assign mode_press = press[0];
  assign inc_press  = press[1];

`ifdef CLK_AUTOREPEAT_EN
  // Armed only by a press taken inside a set mode; a key already held on entry does not repeat.
  logic rpt_armed;

  always_ff @(posedge CP_100MHz) begin
    if (!nCLR)
      rpt_armed <= 1'b0;
    else if (mode_press || !key_db[1] || state_q == RUN || state_q == ILLEGAL)
      rpt_armed <= 1'b0;
    else if (inc_press)
      rpt_armed <= 1'b1;
  end

  assign inc_evt = inc_press | (tick & key_db[1] & rpt_armed);
`else
  assign inc_evt = inc_press;
`endif

  always_ff @(posedge CP_100MHz) begin
    if (!nCLR)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (mode_press) state_d = SET_HR;
      SET_HR:  if (mode_press) state_d = SET_MIN;
      SET_MIN: if (mode_press) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    hr_d  = Hour;
    min_d = Minute;
    sec_d = Second;
    case (state_q)
      RUN: begin
        if (tick) begin
          sec_d = bcd_inc(Second, 8'h59);
          if (Second == 8'h59) begin
            min_d = bcd_inc(Minute, 8'h59);
            if (Minute == 8'h59) hr_d = bcd_inc(Hour, 8'h23);
          end
        end
        // Entering SET_HR clears seconds, overriding a coincident tick.
        if (mode_press) sec_d = 8'h00;
      end
      SET_HR:  if (inc_evt && !mode_press) hr_d = bcd_inc(Hour, 8'h23);
      SET_MIN: if (inc_evt && !mode_press) min_d = bcd_inc(Minute, 8'h59);
      default: ;
    endcase
  end

  always_ff @(posedge CP_100MHz) begin
    if (!nCLR) begin
      Hour   <= 8'h00;
      Minute <= 8'h00;
      Second <= 8'h00;
    end else begin
      Hour   <= hr_d;
      Minute <= min_d;
      Second <= sec_d;
    end
  end

  assign Mode = state_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed self-checking bench for clock_time_ctrl with KEY_STABLE=4.
module tb_clock_time_ctrl;

  localparam int KS = 4;

  logic       clk = 1'b0;
  logic       nCLR, CP_1Hz, KEY_MODE, KEY_INC;
  logic [7:0] Hour, Minute, Second;
  logic [1:0] Mode;

  int checks = 0;
  int errors = 0;

  clock_time_ctrl #(.KEY_STABLE(KS)) dut (
    .CP_100MHz(clk),
    .nCLR(nCLR),
    .CP_1Hz(CP_1Hz),
    .KEY_MODE(KEY_MODE),
    .KEY_INC(KEY_INC),
    .Hour(Hour),
    .Minute(Minute),
    .Second(Second),
    .Mode(Mode)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_1hz();
    CP_1Hz = 1'b1;
    step(2);
    CP_1Hz = 1'b0;
    step(2);
  endtask

  task automatic press(input logic m, input logic i);
    KEY_MODE = m;
    KEY_INC  = i;
    step(10);
    KEY_MODE = 1'b0;
    KEY_INC  = 1'b0;
    step(10);
  endtask

  task automatic inc_n(input int n);
    repeat (n) press(1'b0, 1'b1);
  endtask

  task automatic check_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s);
    check({tag, "_hr"}, Hour, h);
    check({tag, "_min"}, Minute, m);
    check({tag, "_sec"}, Second, s);
  endtask

  initial begin
    nCLR = 1'b0; CP_1Hz = 1'b1; KEY_MODE = 1'b0; KEY_INC = 1'b0;
    step(2);
    check_time("reset", 8'h00, 8'h00, 8'h00);
    check("reset_mode", {6'd0, Mode}, 8'h00);
    nCLR = 1'b1;
    step(3);
    check("hi_at_release", Second, 8'h00);
    CP_1Hz = 1'b0;
    step(2);
    repeat (3) pulse_1hz();
    check_time("run3", 8'h00, 8'h00, 8'h03);
    check("run3_mode", {6'd0, Mode}, 8'h00);
    press(1'b0, 1'b1);
    check_time("run_inc_ignored", 8'h00, 8'h00, 8'h03);

    press(1'b1, 1'b0);
    check("set_hr_mode", {6'd0, Mode}, 8'h01);
    check("set_hr_sec_clr", Second, 8'h00);
    inc_n(5);
    check("hr5", Hour, 8'h05);
    press(1'b1, 1'b0);
    check("set_min_mode", {6'd0, Mode}, 8'h02);
    inc_n(61);
    check("min61", Minute, 8'h01);
    check("min61_hr", Hour, 8'h05);
    press(1'b1, 1'b0);
    check("back_run", {6'd0, Mode}, 8'h00);

    // Debounce: short bursts give nothing, a steady hold gives one step at edge k+6.
    press(1'b1, 1'b0);
    KEY_INC = 1'b1; step(3);
    KEY_INC = 1'b0; step(1);
    KEY_INC = 1'b1; step(3);
    KEY_INC = 1'b0; step(10);
    check("bounce", Hour, 8'h05);
    KEY_INC = 1'b1;
    step(6);
    check("db_k5", Hour, 8'h05);
    step(1);
    check("db_k6", Hour, 8'h06);
    step(10);
    check("db_hold", Hour, 8'h06);
    KEY_INC = 1'b0;
    step(10);

    press(1'b1, 1'b1);
    check("mode_inc_mode", {6'd0, Mode}, 8'h02);
    check("mode_inc_hr", Hour, 8'h06);
    check("mode_inc_min", Minute, 8'h01);

    inc_n(58);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    inc_n(17);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("preload_mode", {6'd0, Mode}, 8'h00);
    repeat (58) pulse_1hz();
    check_time("pre", 8'h23, 8'h59, 8'h58);
    pulse_1hz();
    check_time("r59", 8'h23, 8'h59, 8'h59);
    pulse_1hz();
    check_time("wrap", 8'h00, 8'h00, 8'h00);

    // Tick and MODE press land on the same edge k+6.
    repeat (7) pulse_1hz();
    check("sec7", Second, 8'h07);
    KEY_MODE = 1'b1;
    step(5);
    CP_1Hz = 1'b1;
    step(1);
    check("coll_pre_sec", Second, 8'h07);
    step(1);
    check("coll_sec", Second, 8'h00);
    check("coll_mode", {6'd0, Mode}, 8'h01);
    CP_1Hz = 1'b0;
    KEY_MODE = 1'b0;
    step(10);
    pulse_1hz();
    check("sethr_tick_ign", Second, 8'h00);
    check("sethr_tick_hr", Hour, 8'h00);

    press(1'b1, 1'b0);
    inc_n(30);
    check("min30", Minute, 8'h30);
    nCLR = 1'b0;
    step(1);
    check_time("midreset", 8'h00, 8'h00, 8'h00);
    check("midreset_mode", {6'd0, Mode}, 8'h00);
    nCLR = 1'b1;
    step(3);

`ifdef CLK_AUTOREPEAT_EN
    press(1'b1, 1'b0);
    KEY_INC = 1'b1;
    step(12);
    check("rpt_press", Hour, 8'h01);
    pulse_1hz();
    pulse_1hz();
    check("rpt_hr", Hour, 8'h03);
    KEY_INC = 1'b0;
    step(10);
    pulse_1hz();
    check("rpt_release", Hour, 8'h03);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
